fir_stream_tx: RTL
==================

// Module: fir_stream_tx
// PURPOSE
//  Transmit side of the FIR input protocol: drives PushCoef/CoefAddr/CoefI/CoefQ and PushIn/SampI/SampQ
//  into the complex FIR filter, honouring its StopIn backpressure. Host stages coefficients in a local
//  table, triggers a coefficient burst, then streams samples from an upstream valid/ready source
//  through a small FIFO. Sits between the sample source/host and the FIR core.
// PARAMETERS
//  NCOEF       15   unique coefficients (1 centre + 14 mirrored); CoefAddr range 1..NCOEF
//  FIFO_DEPTH  4    sample FIFO entries, power of 2, >=2
//  SAMP_W      24   sample width per I/Q, signed 1.23
//  COEF_W      27   coefficient width per I/Q, signed 3.24
// PORTS
//  Clk        in   1        clock, rising edge
//  ResetN     in   1        asynchronous active-low reset
//  CfgWr      in   1        write CfgI/CfgQ into table entry CfgAddr
//  CfgAddr    in   4        table index 0..NCOEF-1
//  CfgI/CfgQ  in   COEF_W   coefficient data
//  CfgGo      in   1        pulse: start coefficient burst (honoured in IDLE only)
//  Flush      in   1        pulse: stop accepting samples, drain FIFO, return to IDLE
//  SrcValid   in   1        upstream sample valid
//  SrcReady   out  1        upstream ready; transfer when SrcValid&SrcReady
//  SrcI/SrcQ  in   SAMP_W   upstream sample
//  PushCoef   out  1        coefficient valid to FIR
//  CoefAddr   out  5        1-based coefficient address
//  CoefI/CoefQ out COEF_W   coefficient data
//  StopIn     in   1        FIR backpressure
//  PushIn     out  1        sample valid to FIR
//  SampI/SampQ out SAMP_W   sample data (FIFO head)
//  Busy       out  1        state != IDLE
//  SampCount  out  32       samples delivered since last CfgGo, wraps at 2^32
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, SampCount 0, state IDLE; coef table contents undefined (not reset).
//  FSM IDLE->LOAD on CfgGo; LOAD->GAP after entry NCOEF-1 sent; GAP->STREAM after 1 cycle;
//   STREAM->DRAIN on Flush; DRAIN->IDLE when FIFO empty. CfgGo outside IDLE ignored.
//  LOAD: registered outputs; PushCoef=1 for exactly NCOEF consecutive cycles, first cycle after the
//   CfgGo edge; CoefAddr=k+1 with table[k], k=0..NCOEF-1 ascending. StopIn ignored during LOAD.
//  GAP: PushCoef=0, PushIn=0 for one cycle (FIR leaves coef state only on !PushCoef&&PushIn).
//  CfgWr: accepted in any state; write during LOAD to an entry not yet sent is transmitted with the
//   new value; to an already-sent entry, takes effect on next burst.
//  SrcReady = (state==STREAM) && !full. Upstream may push in LOAD/GAP? No: SrcReady=0 outside STREAM.
//  PushIn = (STREAM||DRAIN) && !empty && !StopIn (combinational from StopIn); SampI/SampQ = FIFO head,
//   valid whenever !empty; head popped on the same edge PushIn=1. SampCount++ per PushIn.
//  Simultaneous push+pop when full: push refused (SrcReady=0 while full, no fall-through).
//  Simultaneous push+pop when empty: no bypass; sample appears at PushIn next cycle (latency 1 min).
//  Flush with FIFO empty: DRAIN lasts one cycle then IDLE. Flush outside STREAM ignored.
//  SampCount cleared on CfgGo acceptance; holds in IDLE.
//  ResetN low mid-burst or mid-stream: immediate abort, outputs 0, FIFO contents discarded.
//  No data held while StopIn=1: FIFO head and PushIn hold; SampI/SampQ stable until popped.
// TESTING
//  1. Load table[k]={I:k+1,Q:-(k+1)}, CfgGo -> 15 cycles PushCoef, CoefAddr 1..15, CoefI 1..15, CoefQ -1..-15.
//  2. After burst, stream 32 samples I=n,Q=~n, StopIn=0 -> one GAP cycle, PushIn in order, SampCount=32.
//  3. StopIn=1 for 10 cycles mid-stream -> PushIn=0, FIFO fills to 4, SrcReady=0; release -> no loss/dup.
//  4. Flush with 3 queued, StopIn toggling -> exactly 3 more PushIn, then Busy=0, SrcReady=0.
//  5. Assert ResetN=0 at CoefAddr=7 -> all outputs 0 same cycle; new CfgGo restarts at CoefAddr=1.
//  6. CfgGo during STREAM and CfgWr of entry 14 during LOAD at CoefAddr=3 -> CfgGo ignored; new entry 14 sent.

Source files
------------

// File: rtl/fir_stream_tx_if.sv
// Bundles the host/config, upstream sample and FIR-side signals of fir_stream_tx.
// The master modport is the transmitter's view; slave is the surrounding environment.
interface fir_stream_tx_if #(
  parameter int SAMP_W = 24,
  parameter int COEF_W = 27
);
  logic                     cfg_wr;
  logic [3:0]               cfg_addr;
  logic signed [COEF_W-1:0] cfg_i;
  logic signed [COEF_W-1:0] cfg_q;
  logic                     cfg_go;
  logic                     flush;
  logic                     src_valid;
  logic                     src_ready;
  logic signed [SAMP_W-1:0] src_i;
  logic signed [SAMP_W-1:0] src_q;
  logic                     push_coef;
  logic [4:0]               coef_addr;
  logic signed [COEF_W-1:0] coef_i;
  logic signed [COEF_W-1:0] coef_q;
  logic                     stop_in;
  logic                     push_in;
  logic signed [SAMP_W-1:0] samp_i;
  logic signed [SAMP_W-1:0] samp_q;
  logic                     busy;
  logic [31:0]              samp_count;

  modport master (
    input  cfg_wr, cfg_addr, cfg_i, cfg_q, cfg_go, flush,
    input  src_valid, src_i, src_q, stop_in,
    output src_ready, push_coef, coef_addr, coef_i, coef_q,
    output push_in, samp_i, samp_q, busy, samp_count
  );

  modport slave (
    output cfg_wr, cfg_addr, cfg_i, cfg_q, cfg_go, flush,
    output src_valid, src_i, src_q, stop_in,
    input  src_ready, push_coef, coef_addr, coef_i, coef_q,
    input  push_in, samp_i, samp_q, busy, samp_count
  );
endinterface

// File: rtl/fir_stream_tx.sv
// FIR input-protocol transmitter: sends a staged coefficient burst, then streams
// upstream samples through a small FIFO to the FIR core under StopIn backpressure.
module fir_stream_tx #(
  parameter int NCOEF      = 15,
  parameter int FIFO_DEPTH = 4,
  parameter int SAMP_W     = 24,
  parameter int COEF_W     = 27
) (
  input logic           clk,
  input logic           rst_n,
  fir_stream_tx_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(NCOEF + 1);

  typedef enum logic [2:0] {IDLE, LOAD, GAP, STREAM, DRAIN} state_t;
  state_t state, state_nxt;

  logic signed [COEF_W-1:0] tbl_i [NCOEF];
  logic signed [COEF_W-1:0] tbl_q [NCOEF];
  logic signed [SAMP_W-1:0] fifo_i [FIFO_DEPTH];
  logic signed [SAMP_W-1:0] fifo_q [FIFO_DEPTH];
  logic [AW:0]              wr_ptr, rd_ptr;
  logic [IW-1:0]            idx, rd_k;
  logic [31:0]              count;
  logic                     go, load_last, load_step, fwd, empty, full, push, pop;
  logic signed [COEF_W-1:0] rd_i, rd_q;

  // output stage registers of the coefficient burst
  logic                     vld_p0;
  logic [4:0]               coef_addr_p0;
  logic signed [COEF_W-1:0] coef_i_p0, coef_q_p0;

  assign go        = (state == IDLE) && bus.cfg_go;
  assign load_last = (idx == IW'(NCOEF));
  assign load_step = go || ((state == LOAD) && !load_last);
  assign rd_k      = go ? '0 : idx;
  // A write landing on the entry being fetched this cycle must win over the stale table value.
  assign fwd       = bus.cfg_wr && (IW'(bus.cfg_addr) == rd_k);
  assign rd_i      = fwd ? bus.cfg_i : ((rd_k < IW'(NCOEF)) ? tbl_i[rd_k] : '0);
  assign rd_q      = fwd ? bus.cfg_q : ((rd_k < IW'(NCOEF)) ? tbl_q[rd_k] : '0);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign push  = bus.src_valid && bus.src_ready;
  assign pop   = ((state == STREAM) || (state == DRAIN)) && !empty && !bus.stop_in;

  assign bus.src_ready  = (state == STREAM) && !full;
  assign bus.push_in    = pop;
  assign bus.samp_i     = empty ? '0 : fifo_i[rd_ptr[AW-1:0]];
  assign bus.samp_q     = empty ? '0 : fifo_q[rd_ptr[AW-1:0]];
  assign bus.busy       = (state != IDLE);
  assign bus.samp_count = count;
  assign bus.push_coef  = vld_p0;
  assign bus.coef_addr  = coef_addr_p0;
  assign bus.coef_i     = coef_i_p0;
  assign bus.coef_q     = coef_q_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cfg_go) state_nxt = LOAD;
      LOAD:    if (load_last)  state_nxt = GAP;
      GAP:                     state_nxt = STREAM;
      STREAM:  if (bus.flush)  state_nxt = DRAIN;
      DRAIN:   if (empty)      state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Coefficient table has no reset; contents are the host's responsibility.
  always_ff @(posedge clk) begin
    if (bus.cfg_wr && (bus.cfg_addr < 4'(NCOEF))) begin
      tbl_i[bus.cfg_addr] <= bus.cfg_i;
      tbl_q[bus.cfg_addr] <= bus.cfg_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0       <= 1'b0;
      coef_addr_p0 <= '0;
      coef_i_p0    <= '0;
      coef_q_p0    <= '0;
      idx          <= '0;
    end else if (load_step) begin
      vld_p0       <= 1'b1;
      coef_addr_p0 <= 5'(rd_k) + 5'd1;
      coef_i_p0    <= rd_i;
      coef_q_p0    <= rd_q;
      idx          <= rd_k + IW'(1);
    end else begin
      vld_p0       <= 1'b0;
      coef_addr_p0 <= '0;
      coef_i_p0    <= '0;
      coef_q_p0    <= '0;
      idx          <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_i[wr_ptr[AW-1:0]] <= bus.src_i;
      fifo_q[wr_ptr[AW-1:0]] <= bus.src_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (go)       count <= '0;
      else if (pop) count <= count + 32'd1;
    end
  end
endmodule
